// File: rtl/sub_pkg.sv
// Shared state encoding and constants for the sequential subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH = 32;
    localparam int SUB_CHUNK = 4;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module fullsubtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_32bit_seq.sv
// Iterative subtractor, CHUNK bits per cycle, valid/ready on both sides.
// Define SUB_SAT_EN to saturate diff on signed overflow.
module sub_32bit_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int CHUNK = SUB_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] res_nx;
    logic [IDXW-1:0]  idx;
    logic             borrow_q;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] d_ch;
    logic [CHUNK:0]   bchain;
    logic             accept;
    logic             last;
    logic             ovf_nx;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state == ST_RUN) && (idx == LAST);

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign bchain[0] = borrow_q;

    for (genvar g = 0; g < CHUNK; g++) begin : g_cell
        fullsubtractor u_fs (
            .x    (a_ch[g]),
            .y    (b_ch[g]),
            .bin  (bchain[g]),
            .d    (d_ch[g]),
            .bout (bchain[g+1])
        );
    end

    // Working result with the current chunk merged in; complete on the last pass.
    always_comb begin
        acc_nx = acc_q;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) begin
                acc_nx[i*CHUNK +: CHUNK] = d_ch;
            end
        end
    end

    assign ovf_nx = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                    (acc_nx[WIDTH-1] ^ a_q[WIDTH-1]);

`ifdef SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_P = WIDTH'(SAT_POS >> (32 - WIDTH));
    localparam logic [WIDTH-1:0] SAT_N = WIDTH'(SAT_NEG >> (32 - WIDTH));

    always_comb begin
        res_nx = acc_nx;
        if (ovf_nx) begin
            res_nx = a_q[WIDTH-1] ? SAT_N : SAT_P;
        end
    end
`else
    assign res_nx = acc_nx;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept)    state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            idx        <= '0;
            borrow_q   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                acc_q    <= '0;
                idx      <= '0;
                borrow_q <= 1'b0;
            end
            if (state == ST_RUN) begin
                acc_q    <= acc_nx;
                borrow_q <= bchain[CHUNK];
                idx      <= idx + 1'b1;
            end
            // diff is only published here, so it holds across the next RUN.
            if (last) begin
                diff       <= res_nx;
                borrow_out <= bchain[CHUNK];
                overflow   <= ovf_nx;
                zero       <= (acc_nx == '0);
            end
        end
    end

endmodule
